// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU datapath definitions.
//   WIDTH             - datapath width of the ALU and divider
//   div_state_t       - divider control states (explicit 2-bit encoding)
//   DIV_ZERO_QUOTIENT - quotient presented on divide-by-zero (all ones)
package alu_pkg;

   localparam int WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      ITER = 2'b01,
      FIX  = 2'b10,
      DONE = 2'b11
   } div_state_t;

   localparam logic [WIDTH-1:0] DIV_ZERO_QUOTIENT = {WIDTH{1'b1}};

endpackage

// File: rtl/div_addsub.sv
// div_addsub: N-bit add/subtract built on the generate/propagate ripple
// carry structure of the ALU adder, widened for the divider's 33-bit
// partial remainder. Subtraction inverts b and feeds sub in as carry-in.
// Ports:
//   a, b - operands
//   sub  - 1 = a - b, 0 = a + b
//   sum  - result modulo 2^N
module div_addsub #(
   parameter int N = 33
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         sub,
   output logic [N-1:0] sum
);

   logic [N-1:0] b_eff_s;
   logic [N-1:0] gen_s;
   logic [N-1:0] prop_s;
   logic [N-1:0] carry_s;

   assign b_eff_s    = sub ? ~b : b;
   assign gen_s      = a & b_eff_s;
   assign prop_s     = a ^ b_eff_s;
   assign carry_s[0] = sub;

   genvar i;
   generate
      for (i = 0; i < N - 1; i++) begin : g_carry
         assign carry_s[i+1] = gen_s[i] | (prop_s[i] & carry_s[i]);
      end
   endgenerate

   assign sum = prop_s ^ carry_s;

endmodule

// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 non-restoring integer divider.
// One quotient bit per clock; signed operands are divided as magnitudes
// and the signs are applied in the FIX cycle.
// Ports:
//   clk, rst_n          - clock (rising edge), async active-low reset
//   start               - request, sampled only in IDLE
//   is_signed           - 1 = two's-complement divide, captured with start
//   dividend, divisor   - operands, captured with start
//   busy                - high in ITER and FIX
//   done                - one-cycle pulse when results are valid
//   quotient, remainder - registered results (held until next update)
//   div_by_zero         - registered flag, valid with done
module div_unit
   import alu_pkg::*;
#(
   parameter int WIDTH = alu_pkg::WIDTH,
   parameter int ITERS = WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int               CNT_W    = $clog2(ITERS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERS - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

   div_state_t       state_r, state_nxt_s;
   logic [CNT_W-1:0] cnt_r;
   logic [WIDTH:0]   p_r;          // partial remainder, sign in bit WIDTH
   logic [WIDTH-1:0] q_r;          // dividend magnitude shifting into quotient
   logic [WIDTH:0]   d_r;          // divisor magnitude, zero-extended
   logic             sign_q_r, sign_r_r;
   logic [WIDTH-1:0] quotient_r, remainder_r;
   logic             dbz_r, busy_r, done_r;

   logic             div_zero_s;
   logic [WIDTH-1:0] dividend_mag_s, divisor_mag_s;
   logic [WIDTH:0]   add_a_s, sum_s;
   logic             add_sub_s;
   logic [WIDTH-1:0] r_fix_s, quot_fin_s, rem_fin_s;

   assign div_zero_s = (divisor == {WIDTH{1'b0}});

   // Next-state logic for the IDLE/ITER/FIX/DONE controller.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_nxt_s = div_zero_s ? DONE : ITER;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         ITER: begin
            if (cnt_r == CNT_LAST) begin
               state_nxt_s = FIX;
            end else begin
               state_nxt_s = ITER;
            end
         end
         FIX:     state_nxt_s = DONE;
         DONE:    state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // Operand magnitudes; negation only for signed operands with MSB set.
   always_comb begin
      if (is_signed && dividend[WIDTH-1]) begin
         dividend_mag_s = ~dividend + ONE;
      end else begin
         dividend_mag_s = dividend;
      end
      if (is_signed && divisor[WIDTH-1]) begin
         divisor_mag_s = ~divisor + ONE;
      end else begin
         divisor_mag_s = divisor;
      end
   end

   // Adder operand select: shifted P +/- D while iterating, P + D in FIX.
   always_comb begin
      if (state_r == FIX) begin
         add_a_s   = p_r;
         add_sub_s = 1'b0;
      end else begin
         add_a_s   = {p_r[WIDTH-1:0], q_r[WIDTH-1]};
         add_sub_s = ~p_r[WIDTH];
      end
   end

   div_addsub #(.N(WIDTH + 1)) u_addsub (
      .a   (add_a_s),
      .b   (d_r),
      .sub (add_sub_s),
      .sum (sum_s)
   );

   // FIX-cycle remainder correction and sign application.
   always_comb begin
      r_fix_s    = p_r[WIDTH] ? sum_s[WIDTH-1:0] : p_r[WIDTH-1:0];
      quot_fin_s = sign_q_r ? (~q_r + ONE) : q_r;
      rem_fin_s  = sign_r_r ? (~r_fix_s + ONE) : r_fix_s;
   end

   // Controller state, datapath registers and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         cnt_r       <= {CNT_W{1'b0}};
         p_r         <= {(WIDTH+1){1'b0}};
         q_r         <= {WIDTH{1'b0}};
         d_r         <= {(WIDTH+1){1'b0}};
         sign_q_r    <= 1'b0;
         sign_r_r    <= 1'b0;
         quotient_r  <= {WIDTH{1'b0}};
         remainder_r <= {WIDTH{1'b0}};
         dbz_r       <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         busy_r  <= (state_nxt_s == ITER) || (state_nxt_s == FIX);
         done_r  <= (state_nxt_s == DONE);
         case (state_r)
            IDLE: begin
               if (start && div_zero_s) begin
                  quotient_r  <= DIV_ZERO_QUOTIENT;
                  remainder_r <= dividend;
                  dbz_r       <= 1'b1;
               end else if (start) begin
                  p_r      <= {(WIDTH+1){1'b0}};
                  q_r      <= dividend_mag_s;
                  d_r      <= {1'b0, divisor_mag_s};
                  sign_q_r <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                  sign_r_r <= is_signed & dividend[WIDTH-1];
                  cnt_r    <= {CNT_W{1'b0}};
                  dbz_r    <= 1'b0;
               end
            end
            ITER: begin
               p_r   <= sum_s;
               q_r   <= {q_r[WIDTH-2:0], ~sum_s[WIDTH]};
               cnt_r <= cnt_r + CNT_ONE;
            end
            FIX: begin
               quotient_r  <= quot_fin_s;
               remainder_r <= rem_fin_s;
            end
            default: begin
               cnt_r <= cnt_r;
            end
         endcase
      end
   end

   assign busy        = busy_r;
   assign done        = done_r;
   assign quotient    = quotient_r;
   assign remainder   = remainder_r;
   assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: self-checking bench for div_unit. Directed vector table,
// ignored-start and mid-operation reset sequences, then random operands
// checked against an arithmetic reference model.
module tb_div_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        is_signed = 1'b0;
   logic [31:0] dividend = 32'd0;
   logic [31:0] divisor = 32'd0;
   logic        busy, done, div_by_zero;
   logic [31:0] quotient, remainder;

   int checks = 0;
   int failures = 0;

   div_unit dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .is_signed   (is_signed),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        sgn;
      logic [31:0] q;
      logic [31:0] r;
      logic        dbz;
   } vec_t;

   vec_t vecs[11];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
      end
   endtask

   // Reference: plain integer division, truncating toward zero.
   task automatic model(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        output logic [31:0] q, output logic [31:0] r, output logic dbz);
      longint sa, sb, lq, lr;
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF; r = a; dbz = 1'b1;
      end else if (!sgn) begin
         q = a / b; r = a % b; dbz = 1'b0;
      end else begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         lq = sa / sb;
         lr = sa % sb;
         q = lq[31:0]; r = lr[31:0]; dbz = 1'b0;
      end
   endtask

   // Issue one operation and watch a fixed 40-cycle window after the
   // accepting edge. Cycle index 0 is the cycle right after that edge.
   // If inj >= 0, a second start with other operands is pulsed at that cycle.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         input int inj,
                         output logic [31:0] q, output logic [31:0] r, output logic dbz,
                         output int lat, output int ndone, output int nbusy);
      @(negedge clk);
      dividend = a; divisor = b; is_signed = sgn; start = 1'b1;
      @(posedge clk);
      lat = -1; ndone = 0; nbusy = 0; q = 32'd0; r = 32'd0; dbz = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (done) begin
            ndone++;
            if (lat < 0) begin
               lat = c; q = quotient; r = remainder; dbz = div_by_zero;
            end
         end
         if (busy) nbusy++;
         if (c == inj) begin
            start = 1'b1; dividend = 32'd1000; divisor = 32'd3; is_signed = 1'b1;
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
   endtask

   task automatic check_op(input string tag, input vec_t v, input int inj);
      logic [31:0] q, r;
      logic dbz;
      int lat, nd, nb;
      run_op(v.a, v.b, v.sgn, inj, q, r, dbz, lat, nd, nb);
      chk({tag, " quotient"}, q, v.q);
      chk({tag, " remainder"}, r, v.r);
      chk({tag, " div_by_zero"}, {31'd0, dbz}, {31'd0, v.dbz});
      chk({tag, " done_count"}, nd, 32'd1);
      chk({tag, " latency"}, lat, v.dbz ? 32'd0 : 32'd33);
      chk({tag, " busy_cycles"}, nb, v.dbz ? 32'd0 : 32'd33);
      chk({tag, " quotient_hold"}, quotient, v.q);
      chk({tag, " remainder_hold"}, remainder, v.r);
   endtask

   initial begin
      vec_t v;
      vecs[0]  = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0};
      vecs[1]  = '{32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0};
      vecs[2]  = '{32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1,          1'b0};
      vecs[3]  = '{32'h1234_5678,  32'd0,          1'b0, 32'hFFFF_FFFF,  32'h1234_5678,  1'b1};
      vecs[4]  = '{32'h1234_5678,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'h1234_5678,  1'b1};
      vecs[5]  = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          1'b0};
      vecs[6]  = '{32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0,          1'b0};
      vecs[7]  = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 32'd1,          32'd0,          1'b0};
      vecs[8]  = '{32'd5,          32'd10,         1'b0, 32'd0,          32'd5,          1'b0};
      vecs[9]  = '{32'hFFFF_FF9C,  32'hFFFF_FFF9,  1'b1, 32'd14,         32'hFFFF_FFFE,  1'b0};
      vecs[10] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'd0,          32'h8000_0000,  1'b0};

      // Reset state.
      #12;
      chk("reset busy", {31'd0, busy}, 32'd0);
      chk("reset done", {31'd0, done}, 32'd0);
      chk("reset quotient", quotient, 32'd0);
      chk("reset remainder", remainder, 32'd0);
      chk("reset div_by_zero", {31'd0, div_by_zero}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed vector table.
      for (int i = 0; i < 11; i++) begin
         check_op($sformatf("vec%0d", i), vecs[i], -1);
      end

      // Second start at cycle 10 of an operation is ignored.
      check_op("ignored_start", vecs[0], 10);

      // Asynchronous reset mid-operation, then a fresh divide.
      @(negedge clk);
      dividend = 32'd100; divisor = 32'd7; is_signed = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (15) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midreset busy", {31'd0, busy}, 32'd0);
      chk("midreset done", {31'd0, done}, 32'd0);
      chk("midreset quotient", quotient, 32'd0);
      chk("midreset remainder", remainder, 32'd0);
      chk("midreset div_by_zero", {31'd0, div_by_zero}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      v = '{32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0};
      check_op("after_reset", v, -1);

      // Random operands against the reference model.
      for (int i = 0; i < 40; i++) begin
         v.a   = $urandom;
         v.sgn = $urandom_range(0, 1);
         case ($urandom_range(0, 3))
            0:       v.b = 32'd0;
            1:       v.b = $urandom_range(1, 20);
            2:       v.b = 32'hFFFF_FFFF - $urandom_range(0, 20);
            default: v.b = $urandom;
         endcase
         model(v.a, v.b, v.sgn, v.q, v.r, v.dbz);
         check_op($sformatf("rand%0d", i), v, -1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
